cr_ifu_ibuf_rd_ctrl: RTL and testbench



---
 rtl/cr_ifu_ibuf_pkg.sv | 14 +
 rtl/cr_ifu_ibuf_rd_ctrl_if.sv | 34 +++
 rtl/cr_ifu_ibuf_rd_sel.sv | 42 ++++
 rtl/cr_ifu_ibuf_rd_ctrl.sv | 107 ++++++++++
 tb/tb_cr_ifu_ibuf_rd_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/cr_ifu_ibuf_pkg.sv
// Shared constants for the IFU halfword instruction buffer.
package cr_ifu_ibuf_pkg;

  localparam int          ENTRY_NUM_DEF = 8;
  localparam int          PTR_W_DEF     = 3;
  localparam int          ENTRY_W       = 17;
  localparam logic [1:0]  OP32_LSB      = 2'b11;

  // RISC-V length decode: low two bits 11 mean a 32-bit encoding.
  function automatic logic is_op32(input logic [15:0] inst);
    return inst[1:0] == OP32_LSB;
  endfunction

endpackage

// File: rtl/cr_ifu_ibuf_rd_ctrl_if.sv
// Entry-side and decode-side signals of the ibuf read controller.
interface cr_ifu_ibuf_rd_ctrl_if
  import cr_ifu_ibuf_pkg::*;
#(
  parameter int ENTRY_NUM = ENTRY_NUM_DEF,
  parameter int PTR_W     = PTR_W_DEF
) ();

  logic [ENTRY_NUM-1:0]         entry_vld;
  logic [ENTRY_NUM*ENTRY_W-1:0] entry_inst;
  logic [ENTRY_NUM-1:0]         entry_acc_err;
  logic                         ibuf_flush;
  logic                         dec_ibuf_ready;
  logic [ENTRY_NUM-1:0]         entry_retire0_en;
  logic [ENTRY_NUM-1:0]         entry_retire1_en;
  logic                         ibuf_dec_inst_vld;
  logic [31:0]                  ibuf_dec_inst;
  logic                         ibuf_dec_inst_32;
  logic                         ibuf_dec_acc_err;
  logic [PTR_W-1:0]             ibuf_rd_ptr;

  modport master (
    input  entry_vld, entry_inst, entry_acc_err, ibuf_flush, dec_ibuf_ready,
    output entry_retire0_en, entry_retire1_en, ibuf_dec_inst_vld,
           ibuf_dec_inst, ibuf_dec_inst_32, ibuf_dec_acc_err, ibuf_rd_ptr
  );

  modport slave (
    output entry_vld, entry_inst, entry_acc_err, ibuf_flush, dec_ibuf_ready,
    input  entry_retire0_en, entry_retire1_en, ibuf_dec_inst_vld,
           ibuf_dec_inst, ibuf_dec_inst_32, ibuf_dec_acc_err, ibuf_rd_ptr
  );

endinterface

// File: rtl/cr_ifu_ibuf_rd_sel.sv
// Combinational head/next entry extraction from the flattened entry vectors.
module cr_ifu_ibuf_rd_sel
  import cr_ifu_ibuf_pkg::*;
#(
  parameter int ENTRY_NUM = ENTRY_NUM_DEF,
  parameter int PTR_W     = PTR_W_DEF
) (
  input  logic [ENTRY_NUM-1:0]         entry_vld,
  input  logic [ENTRY_NUM*ENTRY_W-1:0] entry_inst,
  input  logic [ENTRY_NUM-1:0]         entry_acc_err,
  input  logic [PTR_W-1:0]             rptr,
  output logic [PTR_W-1:0]             next_ptr,
  output logic                         head_vld,
  output logic [15:0]                  head_inst,
  output logic                         head_acc_err,
  output logic                         next_vld,
  output logic [15:0]                  next_inst,
  output logic                         next_acc_err
);

  logic [15:0]          inst_arr [ENTRY_NUM];
  logic [ENTRY_NUM-1:0] unused_bit16;

  genvar gi;
  generate
    for (gi = 0; gi < ENTRY_NUM; gi++) begin : g_unpack
      assign inst_arr[gi]     = entry_inst[gi*ENTRY_W +: 16];
      // Bit 16 of each entry carries no meaning for decode.
      assign unused_bit16[gi] = entry_inst[gi*ENTRY_W + 16];
    end
  endgenerate

  // Power-of-two depth: plain overflow gives the circular wrap.
  assign next_ptr     = rptr + PTR_W'(1);
  assign head_vld     = entry_vld[rptr];
  assign head_inst    = inst_arr[rptr];
  assign head_acc_err = entry_acc_err[rptr];
  assign next_vld     = entry_vld[next_ptr];
  assign next_inst    = inst_arr[next_ptr];
  assign next_acc_err = entry_acc_err[next_ptr];

endmodule

// File: rtl/cr_ifu_ibuf_rd_ctrl.sv
// IFU ibuf read controller: assembles 16/32-bit instructions and retires entries.
// Optional stall counter: define CR_IFU_IBUF_RD_HALF_STALL_CNT_EN.
module cr_ifu_ibuf_rd_ctrl
  import cr_ifu_ibuf_pkg::*;
#(
  parameter int ENTRY_NUM = ENTRY_NUM_DEF,
  parameter int PTR_W     = PTR_W_DEF
) (
  input  logic                  cpuclk,
  input  logic                  cpurst_b,
`ifdef CR_IFU_IBUF_RD_HALF_STALL_CNT_EN
  output logic [15:0]           ibuf_half_stall_cnt,
`endif
  cr_ifu_ibuf_rd_ctrl_if.master bus
);

  logic [PTR_W-1:0]     rptr_reg, rptr_next, next_ptr;
  logic                 inst_vld_reg;
  logic [31:0]          inst_reg, inst_next;
  logic                 inst32_reg;
  logic                 acc_err_reg, acc_err_next;
  logic                 head_vld, head_acc_err, next_vld, next_acc_err;
  logic [15:0]          head_inst, next_inst;
  logic                 slot_free, head_is32, load;
  logic [ENTRY_NUM-1:0] retire0_vec, retire1_vec;

  cr_ifu_ibuf_rd_sel #(.ENTRY_NUM(ENTRY_NUM), .PTR_W(PTR_W)) u_rd_sel (
    .entry_vld     (bus.entry_vld),
    .entry_inst    (bus.entry_inst),
    .entry_acc_err (bus.entry_acc_err),
    .rptr          (rptr_reg),
    .next_ptr      (next_ptr),
    .head_vld      (head_vld),
    .head_inst     (head_inst),
    .head_acc_err  (head_acc_err),
    .next_vld      (next_vld),
    .next_inst     (next_inst),
    .next_acc_err  (next_acc_err)
  );

  // A faulted head is never treated as the low half of a 32-bit instruction.
  always_comb begin
    slot_free    = !inst_vld_reg || bus.dec_ibuf_ready;
    head_is32    = is_op32(head_inst) && !head_acc_err;
    load         = cpurst_b && !bus.ibuf_flush && slot_free && head_vld &&
                   (!head_is32 || next_vld);
    rptr_next    = head_is32 ? rptr_reg + PTR_W'(2) : rptr_reg + PTR_W'(1);
    inst_next    = head_is32 ? {next_inst, head_inst} : {16'h0000, head_inst};
    acc_err_next = head_acc_err || (head_is32 && next_acc_err);
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRY_NUM; gi++) begin : g_retire
      assign retire0_vec[gi] = load && (rptr_reg == PTR_W'(gi));
      assign retire1_vec[gi] = load && head_is32 && (next_ptr == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rptr_reg     <= '0;
      inst_vld_reg <= 1'b0;
      inst_reg     <= '0;
      inst32_reg   <= 1'b0;
      acc_err_reg  <= 1'b0;
    end else if (bus.ibuf_flush) begin
      rptr_reg     <= '0;
      inst_vld_reg <= 1'b0;
    end else if (load) begin
      rptr_reg     <= rptr_next;
      inst_vld_reg <= 1'b1;
      inst_reg     <= inst_next;
      inst32_reg   <= head_is32;
      acc_err_reg  <= acc_err_next;
    end else if (slot_free) begin
      inst_vld_reg <= 1'b0;
    end
  end

`ifdef CR_IFU_IBUF_RD_HALF_STALL_CNT_EN
  logic [15:0] half_stall_cnt_reg;

  // Counts cycles lost waiting for the upper half of a 32-bit instruction.
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      half_stall_cnt_reg <= '0;
    end else if (bus.ibuf_flush) begin
      half_stall_cnt_reg <= '0;
    end else if (slot_free && head_vld && head_is32 && !next_vld &&
                 half_stall_cnt_reg != 16'hFFFF) begin
      half_stall_cnt_reg <= half_stall_cnt_reg + 16'd1;
    end
  end

  assign ibuf_half_stall_cnt = half_stall_cnt_reg;
`endif

  assign bus.entry_retire0_en  = retire0_vec;
  assign bus.entry_retire1_en  = retire1_vec;
  assign bus.ibuf_dec_inst_vld = inst_vld_reg;
  assign bus.ibuf_dec_inst     = inst_reg;
  assign bus.ibuf_dec_inst_32  = inst32_reg;
  assign bus.ibuf_dec_acc_err  = acc_err_reg;
  assign bus.ibuf_rd_ptr       = rptr_reg;

endmodule

// File: tb/tb_cr_ifu_ibuf_rd_ctrl.sv
// Directed bench for cr_ifu_ibuf_rd_ctrl; the bench models entry retirement itself.
`timescale 1ns/1ps
module tb_cr_ifu_ibuf_rd_ctrl;

  logic cpuclk = 1'b0;
  logic cpurst_b;
  int   checks   = 0;
  int   failures = 0;

  always #5 cpuclk = ~cpuclk;

  cr_ifu_ibuf_rd_ctrl_if #(.ENTRY_NUM(8), .PTR_W(3)) bus_if ();

`ifdef CR_IFU_IBUF_RD_HALF_STALL_CNT_EN
  logic [15:0] half_stall_cnt;
  cr_ifu_ibuf_rd_ctrl #(.ENTRY_NUM(8), .PTR_W(3)) dut (
    .cpuclk              (cpuclk),
    .cpurst_b            (cpurst_b),
    .ibuf_half_stall_cnt (half_stall_cnt),
    .bus                 (bus_if)
  );
`else
  cr_ifu_ibuf_rd_ctrl #(.ENTRY_NUM(8), .PTR_W(3)) dut (
    .cpuclk   (cpuclk),
    .cpurst_b (cpurst_b),
    .bus      (bus_if)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input int idx, input logic v, input logic [16:0] inst, input logic err);
    bus_if.entry_vld[idx]              = v;
    bus_if.entry_inst[idx*17 +: 17]    = inst;
    bus_if.entry_acc_err[idx]          = err;
  endtask

  // One clock: entries retired by the DUT this cycle (or flushed) drop their valid.
  task automatic tick();
    logic [7:0] r0, r1;
    #1;
    r0 = bus_if.entry_retire0_en;
    r1 = bus_if.entry_retire1_en;
    @(posedge cpuclk);
    #1;
    if (bus_if.ibuf_flush) bus_if.entry_vld = '0;
    else                   bus_if.entry_vld = bus_if.entry_vld & ~(r0 | r1);
    $display("txn t=%0t vld=%0b inst=%h i32=%0b err=%0b rptr=%0d", $time,
             bus_if.ibuf_dec_inst_vld, bus_if.ibuf_dec_inst, bus_if.ibuf_dec_inst_32,
             bus_if.ibuf_dec_acc_err, bus_if.ibuf_rd_ptr);
  endtask

  initial begin
    cpurst_b              = 1'b0;
    bus_if.entry_vld      = '0;
    bus_if.entry_inst     = '0;
    bus_if.entry_acc_err  = '0;
    bus_if.ibuf_flush     = 1'b0;
    bus_if.dec_ibuf_ready = 1'b1;
    repeat (3) @(posedge cpuclk);
    #1;
    set_entry(0, 1'b1, 17'h04501, 1'b0);
    #1;
    chk("rst_retire0", 32'(bus_if.entry_retire0_en), 32'h0);
    chk("rst_vld",     32'(bus_if.ibuf_dec_inst_vld), 32'h0);
    chk("rst_inst",    bus_if.ibuf_dec_inst, 32'h0);
    chk("rst_i32",     32'(bus_if.ibuf_dec_inst_32), 32'h0);
    chk("rst_err",     32'(bus_if.ibuf_dec_acc_err), 32'h0);
    chk("rst_rptr",    32'(bus_if.ibuf_rd_ptr), 32'h0);

    // 16-bit instruction from entry 0
    cpurst_b = 1'b1;
    #1;
    chk("t1_retire0", 32'(bus_if.entry_retire0_en), 32'h01);
    chk("t1_retire1", 32'(bus_if.entry_retire1_en), 32'h00);
    tick();
    chk("t1_vld",  32'(bus_if.ibuf_dec_inst_vld), 32'h1);
    chk("t1_inst", bus_if.ibuf_dec_inst, 32'h00004501);
    chk("t1_i32",  32'(bus_if.ibuf_dec_inst_32), 32'h0);
    chk("t1_rptr", 32'(bus_if.ibuf_rd_ptr), 32'h1);
    tick();
    chk("t1_idle_vld",  32'(bus_if.ibuf_dec_inst_vld), 32'h0);
    chk("t1_idle_hold", bus_if.ibuf_dec_inst, 32'h00004501);

    // Six back-to-back 16-bit instructions (bit 16 set and ignored), moving rptr to 7
    for (int i = 1; i <= 6; i++)
      set_entry(i, 1'b1, 17'h10000 | (17'h04001 + 17'(i << 8)), 1'b0);
    #1;
    chk("t2_retire0", 32'(bus_if.entry_retire0_en), 32'h02);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("t2_inst%0d", i), bus_if.ibuf_dec_inst, 32'h00004001 + 32'(i << 8));
      chk($sformatf("t2_rptr%0d", i), 32'(bus_if.ibuf_rd_ptr), 32'((i + 1) % 8));
    end

    // 32-bit instruction across the wrap
    set_entry(7, 1'b1, 17'h00093, 1'b0);
    set_entry(0, 1'b1, 17'h00050, 1'b0);
    #1;
    chk("wrap_retire0", 32'(bus_if.entry_retire0_en), 32'h80);
    chk("wrap_retire1", 32'(bus_if.entry_retire1_en), 32'h01);
    tick();
    chk("wrap_inst", bus_if.ibuf_dec_inst, 32'h00500093);
    chk("wrap_i32",  32'(bus_if.ibuf_dec_inst_32), 32'h1);
    chk("wrap_rptr", 32'(bus_if.ibuf_rd_ptr), 32'h1);

    // Flush back to 0, then a split 32-bit instruction
    bus_if.ibuf_flush = 1'b1;
    tick();
    bus_if.ibuf_flush = 1'b0;
    chk("fl1_vld",  32'(bus_if.ibuf_dec_inst_vld), 32'h0);
    chk("fl1_rptr", 32'(bus_if.ibuf_rd_ptr), 32'h0);
    set_entry(0, 1'b1, 17'h00013, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("split_retire0", 32'(bus_if.entry_retire0_en), 32'h0);
      tick();
      chk("split_vld",  32'(bus_if.ibuf_dec_inst_vld), 32'h0);
      chk("split_rptr", 32'(bus_if.ibuf_rd_ptr), 32'h0);
    end
    set_entry(1, 1'b1, 17'h01234, 1'b0);
    #1;
    chk("split_retire0b", 32'(bus_if.entry_retire0_en), 32'h01);
    chk("split_retire1b", 32'(bus_if.entry_retire1_en), 32'h02);
    tick();
    chk("split_inst", bus_if.ibuf_dec_inst, 32'h12340013);
    chk("split_i32",  32'(bus_if.ibuf_dec_inst_32), 32'h1);
    chk("split_rptr2", 32'(bus_if.ibuf_rd_ptr), 32'h2);
`ifdef CR_IFU_IBUF_RD_HALF_STALL_CNT_EN
    chk("split_stall_cnt", 32'(half_stall_cnt), 32'h3);
`endif

    // Backpressure: four stalled cycles, then three back-to-back loads
    bus_if.dec_ibuf_ready = 1'b0;
    set_entry(2, 1'b1, 17'h02221, 1'b0);
    set_entry(3, 1'b1, 17'h03331, 1'b0);
    set_entry(4, 1'b1, 17'h04441, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_retire0", 32'(bus_if.entry_retire0_en), 32'h0);
      tick();
      chk("bp_vld",  32'(bus_if.ibuf_dec_inst_vld), 32'h1);
      chk("bp_inst", bus_if.ibuf_dec_inst, 32'h12340013);
      chk("bp_rptr", 32'(bus_if.ibuf_rd_ptr), 32'h2);
    end
    bus_if.dec_ibuf_ready = 1'b1;
    #1;
    chk("bp_go_retire0", 32'(bus_if.entry_retire0_en), 32'h04);
    tick();
    chk("bp_inst2", bus_if.ibuf_dec_inst, 32'h00002221);
    chk("bp_rptr3", 32'(bus_if.ibuf_rd_ptr), 32'h3);
    tick();
    chk("bp_vld3",  32'(bus_if.ibuf_dec_inst_vld), 32'h1);
    chk("bp_inst3", bus_if.ibuf_dec_inst, 32'h00003331);
    tick();
    chk("bp_inst4", bus_if.ibuf_dec_inst, 32'h00004441);
    chk("bp_rptr5", 32'(bus_if.ibuf_rd_ptr), 32'h5);

    // Access error on a head that looks 32-bit: loads as a single entry
    set_entry(5, 1'b1, 17'h00003, 1'b1);
    #1;
    chk("err_retire0", 32'(bus_if.entry_retire0_en), 32'h20);
    chk("err_retire1", 32'(bus_if.entry_retire1_en), 32'h00);
    tick();
    set_entry(5, 1'b0, 17'h00003, 1'b0);
    chk("err_flag", 32'(bus_if.ibuf_dec_acc_err), 32'h1);
    chk("err_i32",  32'(bus_if.ibuf_dec_inst_32), 32'h0);
    chk("err_inst", bus_if.ibuf_dec_inst, 32'h00000003);
    chk("err_rptr", 32'(bus_if.ibuf_rd_ptr), 32'h6);

    // 32-bit head whose upper half carries the error
    set_entry(6, 1'b1, 17'h00017, 1'b0);
    set_entry(7, 1'b1, 17'h0ABCD, 1'b1);
    tick();
    set_entry(7, 1'b0, 17'h0ABCD, 1'b0);
    chk("err2_inst", bus_if.ibuf_dec_inst, 32'hABCD0017);
    chk("err2_i32",  32'(bus_if.ibuf_dec_inst_32), 32'h1);
    chk("err2_flag", 32'(bus_if.ibuf_dec_acc_err), 32'h1);
    chk("err2_rptr", 32'(bus_if.ibuf_rd_ptr), 32'h0);

    // Flush with a valid head and a pending output
    set_entry(0, 1'b1, 17'h00101, 1'b0);
    tick();
    chk("fl2_pre_vld",  32'(bus_if.ibuf_dec_inst_vld), 32'h1);
    chk("fl2_pre_rptr", 32'(bus_if.ibuf_rd_ptr), 32'h1);
    set_entry(1, 1'b1, 17'h00201, 1'b0);
    bus_if.dec_ibuf_ready = 1'b0;
    bus_if.ibuf_flush     = 1'b1;
    #1;
    chk("fl2_retire0", 32'(bus_if.entry_retire0_en), 32'h0);
    chk("fl2_retire1", 32'(bus_if.entry_retire1_en), 32'h0);
    tick();
    bus_if.ibuf_flush     = 1'b0;
    bus_if.dec_ibuf_ready = 1'b1;
    chk("fl2_vld",  32'(bus_if.ibuf_dec_inst_vld), 32'h0);
    chk("fl2_rptr", 32'(bus_if.ibuf_rd_ptr), 32'h0);
`ifdef CR_IFU_IBUF_RD_HALF_STALL_CNT_EN
    chk("fl2_stall_cnt", 32'(half_stall_cnt), 32'h0);
`endif

    // Asynchronous reset in the middle of a transfer
    set_entry(0, 1'b1, 17'h00505, 1'b0);
    #1;
    chk("ar_retire0", 32'(bus_if.entry_retire0_en), 32'h01);
    tick();
    set_entry(1, 1'b1, 17'h00601, 1'b0);
    #2;
    cpurst_b = 1'b0;
    #1;
    chk("ar_vld",     32'(bus_if.ibuf_dec_inst_vld), 32'h0);
    chk("ar_rptr",    32'(bus_if.ibuf_rd_ptr), 32'h0);
    chk("ar_inst",    bus_if.ibuf_dec_inst, 32'h0);
    chk("ar_retire0", 32'(bus_if.entry_retire0_en), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
